// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer: FWFT frame FIFO; raises VALID per queued frame and streams it after TX_ACK.
// Latency: first word on DOUT the cycle after TX_ACK; VALID drops with the last word, then IFG_CYC idle cycles.
// Backpressure: none upstream (writes while FULL are dropped, OVFL_ERR); FRAME_BUF_TMR_EN triplicates control state.
module tx_frame_buffer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int IFG_CYC = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              WR_LAST,
  output logic              FULL,
  output logic              OVFL_ERR,
  output logic [ADDR_W:0]   FRM_CNT,
  input  logic              TX_ACK,
  output logic              VALID,
  output logic [DATA_W-1:0] DOUT,
  output logic [1:0]        BUF_STATE
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0] IFG_M1 = 8'(IFG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  logic [DATA_W:0]     mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     occ;
  logic [ADDR_W:0]     frm_cnt;
  logic                ovfl_err;
  logic [DATA_W-1:0]   dout;
  logic [DATA_W-1:0]   dout_nx;
  logic                empty;
  logic                full;
  logic                pop;
  logic                wr_acc;
  logic                head_last;
  logic [DATA_W-1:0]   head_data;

  state_t              st_v;
  state_t              st_nx;
  logic                vld_v;
  logic                vld_nx;
  logic [7:0]          gap_v;
  logic [7:0]          gap_nx;

`ifdef FRAME_BUF_TMR_EN
  localparam int N_COPY = 3;
  (* keep = "true", preserve = "true" *) logic [N_COPY-1:0][1:0] st_q;
  (* keep = "true", preserve = "true" *) logic [N_COPY-1:0]      vld_q;
  (* keep = "true", preserve = "true" *) logic [N_COPY-1:0][7:0] gap_q;

  // Bitwise 2-of-3 vote; each copy reloads from the voted value, so a single upset heals in one clock.
  assign st_v  = state_t'((st_q[0] & st_q[1]) | (st_q[0] & st_q[2]) | (st_q[1] & st_q[2]));
  assign vld_v = (vld_q[0] & vld_q[1]) | (vld_q[0] & vld_q[2]) | (vld_q[1] & vld_q[2]);
  assign gap_v = (gap_q[0] & gap_q[1]) | (gap_q[0] & gap_q[2]) | (gap_q[1] & gap_q[2]);
`else
  localparam int N_COPY = 1;
  logic [N_COPY-1:0][1:0] st_q;
  logic [N_COPY-1:0]      vld_q;
  logic [N_COPY-1:0][7:0] gap_q;

  assign st_v  = state_t'(st_q[0]);
  assign vld_v = vld_q[0];
  assign gap_v = gap_q[0];
`endif

  assign head_last = mem[rd_ptr][DATA_W];
  assign head_data = mem[rd_ptr][DATA_W-1:0];
  assign empty     = (occ == '0);
  assign full      = (occ == (ADDR_W+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a write while full is still taken.
  assign wr_acc    = WR_EN && (!full || pop);

  always_comb begin
    st_nx   = st_v;
    vld_nx  = vld_v;
    gap_nx  = gap_v;
    dout_nx = dout;
    pop     = 1'b0;
    case (st_v)
      IDLE: begin
        vld_nx = 1'b0;
        if (frm_cnt != '0) begin
          st_nx  = REQ;
          vld_nx = 1'b1;
        end
      end
      REQ: begin
        vld_nx = 1'b1;
        if (TX_ACK && !empty) begin
          pop     = 1'b1;
          dout_nx = head_data;
          vld_nx  = !head_last;
          gap_nx  = '0;
          st_nx   = head_last ? GAP : STREAM;
        end
      end
      STREAM: begin
        gap_nx = '0;
        if (empty) begin
          st_nx  = GAP;
          vld_nx = 1'b0;
        end else begin
          pop     = 1'b1;
          dout_nx = head_data;
          vld_nx  = !head_last;
          if (head_last) st_nx = GAP;
        end
      end
      GAP: begin
        vld_nx = 1'b0;
        if (gap_v == IFG_M1) st_nx = IDLE;
        else gap_nx = gap_v + 8'd1;
      end
      default: begin
        st_nx  = IDLE;
        vld_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q  <= '0;
      vld_q <= '0;
      gap_q <= '0;
      dout  <= '0;
    end else begin
      st_q  <= {N_COPY{st_nx}};
      vld_q <= {N_COPY{vld_nx}};
      gap_q <= {N_COPY{gap_nx}};
      dout  <= dout_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      frm_cnt  <= '0;
      ovfl_err <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      // A dropped last word is not counted: that partial frame merges into the next one.
      case ({wr_acc && WR_LAST, pop && head_last})
        2'b10:   frm_cnt <= frm_cnt + 1'b1;
        2'b01:   frm_cnt <= frm_cnt - 1'b1;
        default: frm_cnt <= frm_cnt;
      endcase
      if (WR_EN && !wr_acc) ovfl_err <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= {WR_LAST, WR_DATA};
  end

  assign FULL      = full;
  assign OVFL_ERR  = ovfl_err;
  assign FRM_CNT   = frm_cnt;
  assign VALID     = vld_v;
  assign DOUT      = dout;
  assign BUF_STATE = st_v;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: frame-queue model checked every cycle plus directed literal checks.
module tb_tx_frame_buffer;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 16;
  localparam int IFG_CYC = 12;
  localparam int DEPTH   = 512;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              WR_EN = 1'b0;
  logic [DATA_W-1:0] WR_DATA = '0;
  logic              WR_LAST = 1'b0;
  logic              TX_ACK = 1'b0;
  logic              FULL;
  logic              OVFL_ERR;
  logic [ADDR_W:0]   FRM_CNT;
  logic              VALID;
  logic [DATA_W-1:0] DOUT;
  logic [1:0]        BUF_STATE;

  tx_frame_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IFG_CYC(IFG_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .WR_LAST(WR_LAST),
    .FULL(FULL), .OVFL_ERR(OVFL_ERR), .FRM_CNT(FRM_CNT), .TX_ACK(TX_ACK),
    .VALID(VALID), .DOUT(DOUT), .BUF_STATE(BUF_STATE)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a queue of {last,data}; a frame leaves one word per cycle once acknowledged,
  // and VALID re-arms IFG_CYC+1 cycles after the last word of the previous frame.
  logic [16:0] mq[$];
  int          m_frm = 0;
  bit          m_ovfl = 1'b0;
  bit          m_vld = 1'b0;
  logic [15:0] m_dout = '0;
  int          m_left = 0;
  int          m_tend = -1000;
  int          m_sz;
  int          m_frm0;
  bit          m_pop;
  logic [16:0] m_w;

  function automatic int head_frame_len();
    int n = 0;
    foreach (mq[i]) begin
      n++;
      if (mq[i][16]) return n;
    end
    return n;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_frm = 0; m_ovfl = 1'b0; m_vld = 1'b0; m_dout = '0; m_left = 0; m_tend = -1000;
    end else begin
      m_sz = mq.size();
      m_frm0 = m_frm;
      m_pop = 1'b0;
      if (m_left > 0) begin
        m_pop = 1'b1;
        m_left--;
      end else if (m_vld && TX_ACK) begin
        m_pop = 1'b1;
        m_left = head_frame_len() - 1;
      end
      if (m_pop) begin
        m_w = mq.pop_front();
        m_dout = m_w[15:0];
        m_vld = !m_w[16];
        if (m_w[16]) begin
          m_frm--;
          m_tend = cyc + 1;
        end
      end else begin
        m_vld = m_vld || (m_frm0 > 0 && cyc >= m_tend + IFG_CYC);
      end
      if (WR_EN) begin
        if (m_sz < DEPTH || m_pop) begin
          mq.push_back({WR_LAST, WR_DATA});
          if (WR_LAST) m_frm++;
        end else begin
          m_ovfl = 1'b1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && chk_en) begin
      chk("cyc_valid", VALID, m_vld);
      chk("cyc_dout", DOUT, m_dout);
      chk("cyc_frm_cnt", FRM_CNT, m_frm);
      chk("cyc_full", FULL, mq.size() == DEPTH);
      chk("cyc_ovfl", OVFL_ERR, m_ovfl);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [15:0] d, input logic last);
    WR_EN = 1'b1; WR_DATA = d; WR_LAST = last;
    step(1);
    WR_EN = 1'b0; WR_LAST = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 60 && !VALID; k++) step(1);
    chk(name, VALID, 1);
  endtask

  task automatic ack();
    TX_ACK = 1'b1;
    step(1);
    TX_ACK = 1'b0;
  endtask

  logic [15:0] t1_words [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic        t1_vld   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int          tend;
  int          rise;

  initial begin
    step(2);
    chk("rst_valid", VALID, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_frm_cnt", FRM_CNT, 0);
    chk("rst_state", BUF_STATE, 0);
    chk("rst_ovfl", OVFL_ERR, 0);
    RST_N = 1'b1;
    chk_en = 1'b1;
    step(1);

    // Four-word frame.
    wr(16'h1111, 0); wr(16'h2222, 0); wr(16'h3333, 0); wr(16'h4444, 1);
    chk("t1_frm_cnt", FRM_CNT, 1);
    chk("t1_valid_early", VALID, 0);
    step(1);
    chk("t1_valid_rise", VALID, 1);
    ack();
    for (int i = 0; i < 4; i++) begin
      chk("t1_dout", DOUT, t1_words[i]);
      chk("t1_valid", VALID, t1_vld[i]);
      if (i < 3) step(1);
    end
    chk("t1_frm_cnt_end", FRM_CNT, 0);

    // One-word frame.
    wr(16'hABCD, 1);
    wait_valid("t2_wait_valid");
    ack();
    chk("t2_dout", DOUT, 16'hABCD);
    chk("t2_valid", VALID, 0);
    for (int i = 0; i < IFG_CYC; i++) begin
      step(1);
      chk("t2_gap_valid", VALID, 0);
    end

    // Two queued frames: 3 words then 2 words.
    wr(16'hA001, 0); wr(16'hA002, 0); wr(16'hA003, 1);
    wr(16'hB001, 0); wr(16'hB002, 1);
    chk("t3_frm_cnt2", FRM_CNT, 2);
    wait_valid("t3_wait_valid");
    ack();
    chk("t3_a1", DOUT, 16'hA001); step(1);
    chk("t3_a2", DOUT, 16'hA002); step(1);
    chk("t3_a3", DOUT, 16'hA003);
    chk("t3_a3_valid", VALID, 0);
    chk("t3_frm_cnt1", FRM_CNT, 1);
    tend = cyc;
    rise = -1;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (VALID) begin
        rise = cyc;
        break;
      end
    end
    chk("t3_ifg_cycles", rise - tend, IFG_CYC + 1);
    ack();
    chk("t3_b1", DOUT, 16'hB001); chk("t3_b1_valid", VALID, 1); step(1);
    chk("t3_b2", DOUT, 16'hB002); chk("t3_b2_valid", VALID, 0);
    chk("t3_frm_cnt0", FRM_CNT, 0);

    // TX_ACK held through GAP with a frame queued, then through an empty IDLE.
    wr(16'h5555, 1);
    TX_ACK = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("t4_gap_dout", DOUT, 16'hB002);
      chk("t4_gap_state", BUF_STATE, 3);
    end
    TX_ACK = 1'b0;
    wait_valid("t4_wait_valid");
    ack();
    chk("t4_dout", DOUT, 16'h5555);
    TX_ACK = 1'b1;
    step(20);
    chk("t4_idle_state", BUF_STATE, 0);
    chk("t4_idle_dout", DOUT, 16'h5555);
    TX_ACK = 1'b0;

    // Reset in the middle of a five-word frame.
    wr(16'hC001, 0); wr(16'hC002, 0); wr(16'hC003, 0); wr(16'hC004, 0); wr(16'hC005, 1);
    wait_valid("t5_wait_valid");
    ack();
    step(1);
    chk("t5_dout_w2", DOUT, 16'hC002);
    chk("t5_stream_state", BUF_STATE, 2);
    RST_N = 1'b0;
    #1;
    chk("t5_async_valid", VALID, 0);
    chk("t5_async_dout", DOUT, 0);
    chk("t5_async_frm_cnt", FRM_CNT, 0);
    step(2);
    RST_N = 1'b1;
    step(1);
    chk("t5_post_state", BUF_STATE, 0);
    step(20);
    chk("t5_post_valid", VALID, 0);

`ifdef FRAME_BUF_TMR_EN
    // Upset one state copy mid-stream.
    wr(16'hD001, 0); wr(16'hD002, 0); wr(16'hD003, 0); wr(16'hD004, 0); wr(16'hD005, 1);
    wait_valid("tmr_wait_valid");
    ack();
    chk("tmr_d1", DOUT, 16'hD001);
    force dut.st_q = {2'd2, 2'd3, 2'd2};
    #1;
    release dut.st_q;
    step(1);
    chk("tmr_d2", DOUT, 16'hD002);
    chk("tmr_copy_heal", dut.st_q[1], 2);
    step(3);
    chk("tmr_d5", DOUT, 16'hD005);
    step(20);
`endif

    // Fill without any frame end, then overflow.
    WR_EN = 1'b1; WR_LAST = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      WR_DATA = 16'(i);
      step(1);
    end
    WR_EN = 1'b0;
    chk("t6_full", FULL, 1);
    chk("t6_ovfl_before", OVFL_ERR, 0);
    wr(16'hDEAD, 1);
    chk("t6_ovfl", OVFL_ERR, 1);
    chk("t6_full_after", FULL, 1);
    chk("t6_frm_cnt", FRM_CNT, 0);
    step(5);
    chk("t6_valid", VALID, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
